// File: rtl/game_ctrl_pkg.sv
// Shared definitions for the game round controller: state encoding,
// parameter defaults and the saturating level-target calculation.
package game_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    CHECK = 3'd4,
    CLEAR = 3'd5,
    WIN   = 3'd6,
    LOSE  = 3'd7
  } state_e;

  localparam int          DEF_MAX_LEVEL   = 8;
  localparam logic [15:0] DEF_TARGET_BASE = 16'd650;
  localparam logic [15:0] DEF_TARGET_STEP = 16'd500;

  // Wide intermediate so large levels or steps clamp at 16'hFFFF instead of wrapping.
  function automatic logic [15:0] calc_target(input logic [3:0]  lvl,
                                              input logic [15:0] base,
                                              input logic [15:0] step);
    logic [31:0] sum;
    sum = 32'(base) + 32'(lvl) * 32'(step);
    return (sum > 32'h0000_FFFF) ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a synchronous button level; a held button
// yields exactly one single-cycle edge.
module btn_edge (
  input  logic clk,
  input  logic resetn,
  input  logic btn_i,
  output logic edge_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) prev_q <= 1'b0;
    else         prev_q <= btn_i;
  end

  assign edge_o = btn_i & ~prev_q;

endmodule

// File: rtl/game_round_controller.sv
// Round sequencing for the game: loads level targets, runs and pauses the
// round timer, judges the score at time-up and tracks win/lose.
module game_round_controller
  import game_ctrl_pkg::*;
#(
  parameter int          MAX_LEVEL   = DEF_MAX_LEVEL,
  parameter logic [15:0] TARGET_BASE = DEF_TARGET_BASE,
  parameter logic [15:0] TARGET_STEP = DEF_TARGET_STEP
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        pause,
  input  logic        time_up,
  input  logic [15:0] score,
  output logic        timer_enable,
  output logic        time_resetn,
  output logic        move_enable,
  output logic        score_clear,
  output logic [3:0]  level,
  output logic [15:0] target,
  output logic        level_clear,
  output logic        game_over,
  output logic        win
);

  localparam logic [3:0] LAST_LEVEL = 4'(MAX_LEVEL - 1);

  state_e      state_q, state_d;
  logic [3:0]  level_q, level_d;
  logic [15:0] target_q, target_d;
  logic        startEdge, pauseEdge;

  btn_edge u_start_edge (
    .clk    (clk),
    .resetn (resetn),
    .btn_i  (start),
    .edge_o (startEdge)
  );

  btn_edge u_pause_edge (
    .clk    (clk),
    .resetn (resetn),
    .btn_i  (pause),
    .edge_o (pauseEdge)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      level_q  <= 4'd0;
      target_q <= TARGET_BASE;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
    end
  end

  // The timer holds its count (time_resetn high) everywhere except IDLE and LOAD.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    target_d     = target_q;
    timer_enable = 1'b0;
    time_resetn  = 1'b1;
    move_enable  = 1'b0;
    score_clear  = 1'b0;
    level_clear  = 1'b0;
    game_over    = 1'b0;
    win          = 1'b0;

    case (state_q)
      IDLE: begin
        time_resetn = 1'b0;
        if (startEdge) state_d = LOAD;
      end
      LOAD: begin
        time_resetn = 1'b0;
        score_clear = (level_q == 4'd0);
        target_d    = calc_target(level_q, TARGET_BASE, TARGET_STEP);
        state_d     = PLAY;
      end
      PLAY: begin
        timer_enable = 1'b1;
        move_enable  = 1'b1;
        if (time_up)        state_d = CHECK;
        else if (pauseEdge) state_d = PAUSE;
      end
      PAUSE: begin
        if (pauseEdge) state_d = PLAY;
      end
      CHECK: begin
        if (score >= target_q) state_d = (level_q == LAST_LEVEL) ? WIN : CLEAR;
        else                   state_d = LOSE;
      end
      CLEAR: begin
        level_clear = 1'b1;
        if (startEdge) begin
          level_d = level_q + 4'd1;
          state_d = LOAD;
        end
      end
      WIN, LOSE: begin
        game_over = 1'b1;
        win       = (state_q == WIN);
        if (startEdge) begin
          level_d = 4'd0;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign level  = level_q;
  assign target = target_q;

endmodule

// File: doc/game_round_controller.md
GAME_ROUND_CONTROLLER -- requirements
Module: game_round_controller

Interface
REQ-001 SHALL have parameter MAX_LEVEL, default 8, meaning the number of levels per game (1..15).
REQ-002 SHALL have parameter TARGET_BASE, default 16'd650, meaning the level-0 score target.
REQ-003 SHALL have parameter TARGET_STEP, default 16'd500, meaning the target increment per level.
REQ-004 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, synchronous start/continue button level.
REQ-007 SHALL have port pause, input, 1, synchronous pause-toggle button level.
REQ-008 SHALL have port time_up, input, 1, round-timer-expired flag from the timer.
REQ-009 SHALL have port score, input, 16, current game score.
REQ-010 SHALL have port timer_enable, output, 1, high while the round timer counts.
REQ-011 SHALL have port time_resetn, output, 1, active-low timer reload.
REQ-012 SHALL have port move_enable, output, 1, high while the hook and player may move.
REQ-013 SHALL have port score_clear, output, 1, one-cycle pulse clearing the score.
REQ-014 SHALL have port level, output, 4, current level index (0-based).
REQ-015 SHALL have port target, output, 16, score target of the current level.
REQ-016 SHALL have port level_clear, output, 1, high while waiting to advance after a passed level.
REQ-017 SHALL have port game_over, output, 1, high in WIN or LOSE.
REQ-018 SHALL have port win, output, 1, high in WIN only.

Function
REQ-019 SHALL detect rising edges of start and pause internally (registered previous value; edge = current AND NOT previous); held levels produce one edge.
REQ-020 SHALL implement states IDLE, LOAD, PLAY, PAUSE, CHECK, CLEAR, WIN, LOSE; outputs Moore-decoded from the state register.
REQ-021 IDLE: time_resetn=0, all enables 0; start edge -> LOAD.
REQ-022 LOAD (exactly one cycle): time_resetn=0; target <= min(TARGET_BASE + level*TARGET_STEP, 16'hFFFF); score_clear=1 only when level==0; -> PLAY.
REQ-023 PLAY: timer_enable=1, move_enable=1, time_resetn=1; time_up -> CHECK; else pause edge -> PAUSE.
REQ-024 time_up and pause edge in the same PLAY cycle: time_up wins, pause edge discarded.
REQ-025 PAUSE: timer_enable=0, move_enable=0, time_resetn=1; pause edge -> PLAY; start edge ignored.
REQ-026 CHECK (one cycle, enables 0): score >= target (unsigned) and level==MAX_LEVEL-1 -> WIN; score >= target otherwise -> CLEAR; score < target -> LOSE.
REQ-027 CLEAR: level_clear=1; start edge -> level <= level+1, -> LOAD.
REQ-028 WIN/LOSE: game_over=1 (win=1 in WIN); start edge -> level <= 0, -> LOAD (score cleared there).
REQ-029 Pause edges SHALL be ignored in every state except PLAY and PAUSE.
REQ-030 target SHALL change only in LOAD and hold otherwise.

Reset
REQ-031 On resetn low, immediately: state IDLE, level 0, target TARGET_BASE, edge registers 0; outputs timer_enable 0, time_resetn 0, move_enable 0, score_clear 0, level_clear 0, game_over 0, win 0.
REQ-032 Reset asserted mid-round SHALL abandon the round; first start edge after release begins at level 0.

Structure
REQ-033 State encoding and parameter defaults SHALL live in shared package game_ctrl_pkg.
REQ-034 Edge detection SHALL be sub-module btn_edge, instantiated once per button.

Verification
REQ-035 Reset, start edge -> LOAD 1 cycle (time_resetn 0, score_clear 1, target 650), then PLAY with timer_enable 1.
REQ-036 PLAY, pause edge, pause held 10 cycles, second edge -> timer_enable 0 during PAUSE, single toggle per press, returns to PLAY.
REQ-037 Level 0, score 700, time_up -> CHECK then CLEAR; start edge -> level 1, target 1150, score_clear 0.
REQ-038 Level 7, score 4150, time_up -> WIN, game_over 1, win 1; start edge -> level 0, score_clear pulse.
REQ-039 Score 649 at level 0, time_up coincident with pause edge -> CHECK -> LOSE, win 0, PAUSE never entered.
REQ-040 resetn low during PAUSE at level 3 -> IDLE, level 0, outputs at reset values asynchronously.
